// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised pipeline boundary register.
//
// Carries {valid, ctrl, data} through STAGES chained register slices with a
// global stall, a flush and bubble insertion at slice 0. Invalid slots always
// hold CTRL_IDLE in their control field so no enable can leak downstream.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous, active-high reset
//   STALL      every slice holds
//   FLUSH      invalidate every slice (overrides STALL and BUBBLE)
//   BUBBLE     slice 0 captures an invalid entry instead of the inputs
//   VALID_IN   upstream entry valid
//   CTRL_IN    upstream control field
//   DATA_IN    upstream payload
//   VALID_OUT  last-slice valid
//   CTRL_OUT   last-slice control (CTRL_IDLE whenever VALID_OUT=0)
//   DATA_OUT   last-slice payload
//   PARITY_ERR registered parity-mismatch pulse (only with PIPE_STAGE_PARITY_EN)
//
// Optional feature macro: PIPE_STAGE_PARITY_EN adds per-slice even parity
// over {ctrl,data} and the PARITY_ERR output.

module pipe_stage_reg #(
  parameter int unsigned          CTRL_W    = 2,
  parameter int unsigned          DATA_W    = 69,
  parameter int unsigned          STAGES    = 1,
  parameter logic [CTRL_W-1:0]    CTRL_IDLE = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              BUBBLE,
  input  logic              VALID_IN,
  input  logic [CTRL_W-1:0] CTRL_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              VALID_OUT,
  output logic [CTRL_W-1:0] CTRL_OUT,
`ifdef PIPE_STAGE_PARITY_EN
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              PARITY_ERR
`else
  output logic [DATA_W-1:0] DATA_OUT
`endif
);

  logic              valid_q [STAGES];
  logic [CTRL_W-1:0] ctrl_q  [STAGES];
  logic [DATA_W-1:0] data_q  [STAGES];

  logic              valid0_next;
  logic [CTRL_W-1:0] ctrl0_next;

  // A bubble or an invalid input both produce an idle control word.
  always_comb begin
    valid0_next = 1'b0;
    ctrl0_next  = CTRL_IDLE;
    if (!BUBBLE && VALID_IN) begin
      valid0_next = 1'b1;
      ctrl0_next  = CTRL_IN;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= CTRL_IDLE;
        data_q[k]  <= '0;
      end
    end else if (FLUSH) begin
      // Payload is deliberately left in place; only validity and control die.
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= CTRL_IDLE;
      end
    end else if (!STALL) begin
      valid_q[0] <= valid0_next;
      ctrl_q[0]  <= ctrl0_next;
      data_q[0]  <= DATA_IN;
      for (int k = 1; k < int'(STAGES); k++) begin
        valid_q[k] <= valid_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  assign VALID_OUT = valid_q[STAGES-1];
  assign CTRL_OUT  = ctrl_q[STAGES-1];
  assign DATA_OUT  = data_q[STAGES-1];

`ifdef PIPE_STAGE_PARITY_EN
  logic par_q [STAGES];

  // Parity follows the data rules: captured at slice 0, held on stall/flush.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        par_q[k] <= 1'b0;
      end
    end else if (!FLUSH && !STALL) begin
      par_q[0] <= ^{ctrl0_next, DATA_IN};
      for (int k = 1; k < int'(STAGES); k++) begin
        par_q[k] <= par_q[k-1];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PARITY_ERR <= 1'b0;
    end else begin
      PARITY_ERR <= VALID_OUT && ((^{CTRL_OUT, DATA_OUT}) != par_q[STAGES-1]);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (STAGES=1,2,3) share one stimulus
// stream. The reference is a history of accepted entries (newest first); the
// expected output of an S-slice register is simply the entry S-1 places back.

module tb_pipe_stage_reg;

  typedef struct packed {
    logic        v;
    logic [1:0]  c;
    logic [68:0] d;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic        BUBBLE = 1'b0;
  logic        VALID_IN = 1'b0;
  logic [1:0]  CTRL_IN = '0;
  logic [68:0] DATA_IN = '0;

  logic        v1, v2, v3;
  logic [1:0]  c1, c2, c3;
  logic [68:0] d1, d2, d3;
`ifdef PIPE_STAGE_PARITY_EN
  logic        perr1, perr2, perr3;
  logic        perr_window = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  ent_t hist[$] = '{ent_t'(0), ent_t'(0), ent_t'(0), ent_t'(0)};

  always #5 CLK = ~CLK;

`ifdef PIPE_STAGE_PARITY_EN
  pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .STAGES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .BUBBLE(BUBBLE),
    .VALID_IN(VALID_IN), .CTRL_IN(CTRL_IN), .DATA_IN(DATA_IN),
    .VALID_OUT(v1), .CTRL_OUT(c1), .DATA_OUT(d1), .PARITY_ERR(perr1));
  pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .STAGES(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .BUBBLE(BUBBLE),
    .VALID_IN(VALID_IN), .CTRL_IN(CTRL_IN), .DATA_IN(DATA_IN),
    .VALID_OUT(v2), .CTRL_OUT(c2), .DATA_OUT(d2), .PARITY_ERR(perr2));
  pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .STAGES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .BUBBLE(BUBBLE),
    .VALID_IN(VALID_IN), .CTRL_IN(CTRL_IN), .DATA_IN(DATA_IN),
    .VALID_OUT(v3), .CTRL_OUT(c3), .DATA_OUT(d3), .PARITY_ERR(perr3));
`else
  pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .STAGES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .BUBBLE(BUBBLE),
    .VALID_IN(VALID_IN), .CTRL_IN(CTRL_IN), .DATA_IN(DATA_IN),
    .VALID_OUT(v1), .CTRL_OUT(c1), .DATA_OUT(d1));
  pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .STAGES(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .BUBBLE(BUBBLE),
    .VALID_IN(VALID_IN), .CTRL_IN(CTRL_IN), .DATA_IN(DATA_IN),
    .VALID_OUT(v2), .CTRL_OUT(c2), .DATA_OUT(d2));
  pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .STAGES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .BUBBLE(BUBBLE),
    .VALID_IN(VALID_IN), .CTRL_IN(CTRL_IN), .DATA_IN(DATA_IN),
    .VALID_OUT(v3), .CTRL_OUT(c3), .DATA_OUT(d3));
`endif

  // Reference model: a history of entries, newest first.
  always @(posedge CLK or posedge RESET) begin
    ent_t e;
    if (RESET) begin
      hist.delete();
      for (int i = 0; i < 4; i++) hist.push_back(ent_t'(0));
    end else if (FLUSH) begin
      foreach (hist[i]) begin
        hist[i].v = 1'b0;
        hist[i].c = 2'b00;
      end
    end else if (!STALL) begin
      e.v = VALID_IN && !BUBBLE;
      e.c = e.v ? CTRL_IN : 2'b00;
      e.d = DATA_IN;
      hist.push_front(e);
      void'(hist.pop_back());
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("s1_valid", 128'(v1), 128'(hist[0].v));
    chk("s1_ctrl",  128'(c1), 128'(hist[0].c));
    chk("s1_data",  128'(d1), 128'(hist[0].d));
    chk("s2_valid", 128'(v2), 128'(hist[1].v));
    chk("s2_ctrl",  128'(c2), 128'(hist[1].c));
    chk("s2_data",  128'(d2), 128'(hist[1].d));
    chk("s3_valid", 128'(v3), 128'(hist[2].v));
    chk("s3_ctrl",  128'(c3), 128'(hist[2].c));
    chk("s3_data",  128'(d3), 128'(hist[2].d));
`ifdef PIPE_STAGE_PARITY_EN
    if (!perr_window) chk("perr1_clean", 128'(perr1), 128'(0));
    chk("perr2_clean", 128'(perr2), 128'(0));
    chk("perr3_clean", 128'(perr3), 128'(0));
`endif
  end

  task automatic step(input logic vi, input logic [1:0] ci, input logic [68:0] di,
                      input logic st, input logic fl, input logic bu);
    @(negedge CLK);
    VALID_IN = vi; CTRL_IN = ci; DATA_IN = di;
    STALL = st; FLUSH = fl; BUBBLE = bu;
    @(posedge CLK);
    #1;
  endtask

  localparam logic [68:0] DT1 = 69'h1_2345_6789_ABCD_EF01;
  localparam logic [68:0] DA = 69'h0A, DB = 69'h0B, DC = 69'h0C, DD = 69'h0D, DE = 69'h0E;

  // {valid, ctrl, data, stall, flush, bubble}
  typedef struct packed {
    logic v; logic [1:0] c; logic [68:0] d; logic st; logic fl; logic bu;
  } vec_t;
  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 2'd1, 69'h101, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 69'h102, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'd3, 69'h103, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 69'h104, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 69'h105, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 2'd2, 69'h106, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd3, 69'h107, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 69'h108, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd2, 69'h109, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 2'd3, 69'h10A, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 69'h10B, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 2'd1, 69'h1F_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'd2, 69'h10D, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 2'd3, 69'h10E, 1'b0, 1'b0, 1'b0};

    // Reset held across the first edge.
    @(posedge CLK); #1;
    chk("rst_valid", 128'(v1), 128'(0));
    chk("rst_ctrl",  128'(c1), 128'(0));
    chk("rst_data",  128'(d3), 128'(0));
    @(negedge CLK);
    RESET = 1'b0;

    // Single boundary register capture.
    step(1'b1, 2'b11, DT1, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 128'(v1), 128'(1));
    chk("t1_ctrl",  128'(c1), 128'(3));
    chk("t1_data",  128'(d1), 128'(DT1));

    // Three-slice stream with a two-cycle stall.
    step(1'b1, 2'd1, DA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, DB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, DC, 1'b0, 1'b0, 1'b0);
    chk("s3_A", 128'(d3), 128'(DA));
    step(1'b1, 2'd1, DD, 1'b1, 1'b0, 1'b0);
    chk("s3_stall1", 128'(d3), 128'(DA));
    step(1'b1, 2'd1, DD, 1'b1, 1'b0, 1'b0);
    chk("s3_stall2", 128'(d3), 128'(DA));
    step(1'b1, 2'd1, DD, 1'b0, 1'b0, 1'b0);
    chk("s3_B", 128'(d3), 128'(DB));
    chk("s3_B_ctrl", 128'(c3), 128'(2));
    step(1'b1, 2'd2, DE, 1'b0, 1'b0, 1'b0);
    chk("s3_C", 128'(d3), 128'(DC));

    // Flush together with stall on a full two-slice register.
    step(1'b1, 2'd1, 69'h77, 1'b1, 1'b1, 1'b0);
    chk("fl_valid", 128'(v2), 128'(0));
    chk("fl_ctrl",  128'(c2), 128'(0));
    chk("fl_data_hold", 128'(d2), 128'(DD));
    step(1'b0, 2'd0, 69'h78, 1'b0, 1'b0, 1'b0);
    chk("fl_slice0_valid", 128'(v2), 128'(0));
    chk("fl_slice0_data",  128'(d2), 128'(DE));

    // Bubble insertion, and bubble dropped under stall.
    step(1'b1, 2'b11, 69'h55, 1'b0, 1'b0, 1'b1);
    chk("bub_valid", 128'(v1), 128'(0));
    chk("bub_ctrl",  128'(c1), 128'(0));
    chk("bub_data",  128'(d1), 128'(69'h55));
    step(1'b1, 2'd2, 69'h56, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 69'h57, 1'b1, 1'b0, 1'b1);
    chk("bubst_valid", 128'(v1), 128'(1));
    chk("bubst_ctrl",  128'(c1), 128'(2));
    chk("bubst_data",  128'(d1), 128'(69'h56));
    step(1'b1, 2'd1, 69'h58, 1'b0, 1'b0, 1'b0);
    chk("bub_dropped", 128'(v1), 128'(1));
    chk("bub_dropped_d", 128'(d1), 128'(69'h58));

    // Invalid input forces idle control.
    step(1'b0, 2'b11, 69'h59, 1'b0, 1'b0, 1'b0);
    chk("inv_ctrl", 128'(c1), 128'(0));
    step(1'b1, 2'd3, 69'h5A, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_valid", 128'(v1), 128'(0));
    chk("arst_ctrl",  128'(c1), 128'(0));
    chk("arst_data",  128'(d1), 128'(0));
    chk("arst_data3", 128'(d3), 128'(0));
    @(negedge CLK);
    RESET = 1'b0;
    VALID_IN = 1'b1; CTRL_IN = 2'd2; DATA_IN = 69'h5B;
    STALL = 1'b0; FLUSH = 1'b0; BUBBLE = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_valid", 128'(v1), 128'(1));
    chk("post_rst_data",  128'(d1), 128'(69'h5B));

    // Mixed directed vectors, checked by the model every cycle.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].v, vecs[i].c, vecs[i].d, vecs[i].st, vecs[i].fl, vecs[i].bu);
    end

`ifdef PIPE_STAGE_PARITY_EN
    step(1'b1, 2'd3, 69'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 69'h4321, 1'b0, 1'b0, 1'b0);
    chk("par_clean", 128'(perr1), 128'(0));
    @(negedge CLK);
    #2;
    perr_window = 1'b1;
    dut1.data_q[0] = dut1.data_q[0] ^ 69'h1;
    VALID_IN = 1'b1; CTRL_IN = 2'd2; DATA_IN = 69'h999;
    STALL = 1'b0; FLUSH = 1'b0; BUBBLE = 1'b0;
    @(posedge CLK); #1;
    chk("par_err_hi", 128'(perr1), 128'(1));
    step(1'b1, 2'd1, 69'h998, 1'b0, 1'b0, 1'b0);
    chk("par_err_lo", 128'(perr1), 128'(0));
    perr_window = 1'b0;
    step(1'b0, 2'd0, 69'h0, 1'b0, 1'b0, 1'b0);
`endif

    step(1'b0, 2'd0, 69'h0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
